// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two requesters (p0, p1) share one SdramCtrl command/response stream.
//   Commands are granted round-robin over a zero-latency combinational mux.
//   Every accepted read pushes the issuing port ID into an in-order FIFO, and
//   the FIFO head routes each returning read response back to its issuer.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   pN_cmd_*                   requester N command stream (valid/ready + payload)
//   pN_rsp_*                   requester N read-response stream
//   io_cmd_*                   granted command stream towards SdramCtrl
//   io_rsp_*                   read-response stream from SdramCtrl
//   io_overflow_err            sticky flag: response arrived with no read pending
//
// Command lock FSM
//   state     | meaning
//   ST_FREE   | no command stalled, grant follows round-robin
//   ST_LOCKED | a command was offered but not taken, grant held on locked_port

module sdram_port_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int MASK_WIDTH    = 2,
  parameter int PENDING_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_cmd_valid,
  output logic                  p0_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] p0_cmd_payload_address,
  input  logic                  p0_cmd_payload_write,
  input  logic [DATA_WIDTH-1:0] p0_cmd_payload_data,
  input  logic [MASK_WIDTH-1:0] p0_cmd_payload_mask,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_payload_data,

  input  logic                  p1_cmd_valid,
  output logic                  p1_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] p1_cmd_payload_address,
  input  logic                  p1_cmd_payload_write,
  input  logic [DATA_WIDTH-1:0] p1_cmd_payload_data,
  input  logic [MASK_WIDTH-1:0] p1_cmd_payload_mask,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_payload_data,

  output logic                  io_cmd_valid,
  input  logic                  io_cmd_ready,
  output logic [ADDR_WIDTH-1:0] io_cmd_payload_address,
  output logic                  io_cmd_payload_write,
  output logic [DATA_WIDTH-1:0] io_cmd_payload_data,
  output logic [MASK_WIDTH-1:0] io_cmd_payload_mask,
  input  logic                  io_rsp_valid,
  output logic                  io_rsp_ready,
  input  logic [DATA_WIDTH-1:0] io_rsp_payload_data,
  output logic                  io_overflow_err
);

  localparam int PTR_W = $clog2(PENDING_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t state, state_next;
  logic        locked_port, locked_port_next;
  logic        rr_last;
  logic        grant;
  logic        sel_valid;
  logic        sel_write;
  logic        gate_block;
  logic        cmd_fire;

  logic [PENDING_DEPTH-1:0] pend_id;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     fifo_empty, fifo_full;
  logic                     head_id;
  logic                     push, pop;

  // Full-gating looks only at the registered count; a pop in the same cycle
  // frees its slot for the next cycle, never for the current one.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(PENDING_DEPTH));
  assign head_id    = pend_id[rd_ptr];

  always_comb begin
    grant            = ~rr_last;
    state_next       = state;
    locked_port_next = locked_port;

    if (state == ST_LOCKED)
      grant = locked_port;
    else if (p0_cmd_valid && !p1_cmd_valid)
      grant = 1'b0;
    else if (p1_cmd_valid && !p0_cmd_valid)
      grant = 1'b1;

    sel_valid              = grant ? p1_cmd_valid           : p0_cmd_valid;
    sel_write              = grant ? p1_cmd_payload_write   : p0_cmd_payload_write;
    io_cmd_payload_address = grant ? p1_cmd_payload_address : p0_cmd_payload_address;
    io_cmd_payload_write   = sel_write;
    io_cmd_payload_data    = grant ? p1_cmd_payload_data    : p0_cmd_payload_data;
    io_cmd_payload_mask    = grant ? p1_cmd_payload_mask    : p0_cmd_payload_mask;

    // A read is withheld while no slot is free to remember where its data goes.
    gate_block   = sel_valid && !sel_write && fifo_full;
    io_cmd_valid = sel_valid && !gate_block;
    p0_cmd_ready = io_cmd_ready && !grant && !gate_block;
    p1_cmd_ready = io_cmd_ready &&  grant && !gate_block;
    cmd_fire     = io_cmd_valid && io_cmd_ready;

    if (cmd_fire) begin
      state_next = ST_FREE;
    end else if (io_cmd_valid) begin
      state_next       = ST_LOCKED;
      locked_port_next = grant;
    end
  end

  always_comb begin
    p0_rsp_valid = io_rsp_valid && !fifo_empty && !head_id;
    p1_rsp_valid = io_rsp_valid && !fifo_empty &&  head_id;
    // Orphan responses are swallowed so SdramCtrl can never wedge on them.
    io_rsp_ready = fifo_empty || (head_id ? p1_rsp_ready : p0_rsp_ready);
    push         = cmd_fire && !sel_write;
    pop          = io_rsp_valid && io_rsp_ready && !fifo_empty;
  end

  assign p0_rsp_payload_data = io_rsp_payload_data;
  assign p1_rsp_payload_data = io_rsp_payload_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_FREE;
      locked_port     <= 1'b0;
      rr_last         <= 1'b1;
      pend_id         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      io_overflow_err <= 1'b0;
    end else begin
      state       <= state_next;
      locked_port <= locked_port_next;
      if (cmd_fire)
        rr_last <= grant;
      if (push) begin
        pend_id[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      if (io_rsp_valid && fifo_empty)
        io_overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: reset-state vector table, directed multi-cycle
// scenarios and randomized traffic. The bench plays both requesters and the
// SdramCtrl (a small word memory answering reads in order).

module tb_sdram_port_arbiter;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int MW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          c_valid [2];
  logic          c_write [2];
  logic [AW-1:0] c_addr  [2];
  logic [DW-1:0] c_data  [2];
  logic [MW-1:0] c_mask  [2];
  logic          r_ready [2];
  logic          cmd_rdy [2];
  logic          rsp_vld [2];
  logic [DW-1:0] rsp_dat [2];

  logic          io_cmd_valid, io_cmd_ready, io_cmd_payload_write;
  logic [AW-1:0] io_cmd_payload_address;
  logic [DW-1:0] io_cmd_payload_data;
  logic [MW-1:0] io_cmd_payload_mask;
  logic          io_rsp_valid, io_rsp_ready, io_overflow_err;
  logic [DW-1:0] io_rsp_payload_data;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                       .PENDING_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_cmd_valid(c_valid[0]), .p0_cmd_ready(cmd_rdy[0]),
    .p0_cmd_payload_address(c_addr[0]), .p0_cmd_payload_write(c_write[0]),
    .p0_cmd_payload_data(c_data[0]), .p0_cmd_payload_mask(c_mask[0]),
    .p0_rsp_valid(rsp_vld[0]), .p0_rsp_ready(r_ready[0]),
    .p0_rsp_payload_data(rsp_dat[0]),
    .p1_cmd_valid(c_valid[1]), .p1_cmd_ready(cmd_rdy[1]),
    .p1_cmd_payload_address(c_addr[1]), .p1_cmd_payload_write(c_write[1]),
    .p1_cmd_payload_data(c_data[1]), .p1_cmd_payload_mask(c_mask[1]),
    .p1_rsp_valid(rsp_vld[1]), .p1_rsp_ready(r_ready[1]),
    .p1_rsp_payload_data(rsp_dat[1]),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_payload_address(io_cmd_payload_address),
    .io_cmd_payload_write(io_cmd_payload_write),
    .io_cmd_payload_data(io_cmd_payload_data),
    .io_cmd_payload_mask(io_cmd_payload_mask),
    .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
    .io_rsp_payload_data(io_rsp_payload_data),
    .io_overflow_err(io_overflow_err)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } cmd_t;

  typedef struct {
    logic          v0, w0, v1, w1, cr, rv;
    logic          ev;
    logic [AW-1:0] ea;
    logic          er0, er1;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Requester command queues, SdramCtrl side and reference model state.
  cmd_t          cmdq  [2][$];
  logic [DW-1:0] exp_q [2][$];
  logic [DW-1:0] got   [2][$];
  int            pend_q[$];
  logic [DW-1:0] sdq[$];
  int            fired[$];
  logic [DW-1:0] mem [8];
  int            last_port;
  bit            held;
  int            held_port;
  bit            exp_ovf;
  int            cmd_prob, rsp_prob;
  int            rdy_prob [2];
  bit            inject;
  vec_t          vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, w0, v1, w1, cr, rv, ev,
                              input logic [AW-1:0] ea, input logic er0, er1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.v1 = v1; v.w1 = w1; v.cr = cr; v.rv = rv;
    v.ev = ev; v.ea = ea; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  function automatic cmd_t mkcmd(input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [MW-1:0] m);
    cmd_t c;
    c.write = w; c.addr = a; c.data = d; c.mask = m;
    return c;
  endfunction

  // One clock: drive at negedge, check combinational outputs 1 time unit
  // later against the reference model, then advance the model.
  task automatic cycle();
    int   g, h;
    bit   blk, ev, fire, rfire, was_empty;
    cmd_t c;
    int   idx;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      c_valid[n] = cmdq[n].size() > 0;
      if (c_valid[n]) begin
        c = cmdq[n][0];
        c_write[n] = c.write; c_addr[n] = c.addr; c_data[n] = c.data; c_mask[n] = c.mask;
      end
      r_ready[n] = $urandom_range(99) < rdy_prob[n];
    end
    io_cmd_ready = $urandom_range(99) < cmd_prob;
    if (inject) begin
      io_rsp_valid = 1'b1;
      io_rsp_payload_data = 16'hDEAD;
    end else begin
      io_rsp_valid = sdq.size() > 0 && $urandom_range(99) < rsp_prob;
      io_rsp_payload_data = (sdq.size() > 0) ? sdq[0] : '0;
    end
    #1;
    g = -1;
    if (held) g = held_port;
    else if (c_valid[0] && c_valid[1]) g = 1 - last_port;
    else if (c_valid[0]) g = 0;
    else if (c_valid[1]) g = 1;
    blk = (g >= 0) && !c_write[g] && pend_q.size() == DEPTH;
    ev  = (g >= 0) && !blk;
    chk("io_cmd_valid", 32'(io_cmd_valid), 32'(ev));
    for (int n = 0; n < 2; n++)
      if (c_valid[n])
        chk($sformatf("p%0d_cmd_ready", n), 32'(cmd_rdy[n]),
            32'(io_cmd_ready && g == n && !blk));
    if (ev) begin
      chk("io_cmd_address", 32'(io_cmd_payload_address), 32'(c_addr[g]));
      chk("io_cmd_write", 32'(io_cmd_payload_write), 32'(c_write[g]));
      chk("io_cmd_mask", 32'(io_cmd_payload_mask), 32'(c_mask[g]));
      if (c_write[g]) chk("io_cmd_data", 32'(io_cmd_payload_data), 32'(c_data[g]));
    end
    fire = ev && io_cmd_ready;
    was_empty = pend_q.size() == 0;
    rfire = 1'b0;
    chk("io_overflow_err", 32'(io_overflow_err), 32'(exp_ovf));
    if (was_empty) begin
      chk("io_rsp_ready_empty", 32'(io_rsp_ready), 32'd1);
      chk("p0_rsp_valid_empty", 32'(rsp_vld[0]), 32'd0);
      chk("p1_rsp_valid_empty", 32'(rsp_vld[1]), 32'd0);
      if (io_rsp_valid) exp_ovf = 1'b1;
    end else begin
      h = pend_q[0];
      chk($sformatf("p%0d_rsp_valid", h), 32'(rsp_vld[h]), 32'(io_rsp_valid));
      chk($sformatf("p%0d_rsp_valid_idle", 1 - h), 32'(rsp_vld[1 - h]), 32'd0);
      chk("io_rsp_ready", 32'(io_rsp_ready), 32'(r_ready[h]));
      rfire = io_rsp_valid && r_ready[h];
      if (rfire) begin
        chk($sformatf("p%0d_rsp_data", h), 32'(rsp_dat[h]), 32'(exp_q[h][0]));
        chk($sformatf("p%0d_rsp_data_fanout", 1 - h), 32'(rsp_dat[1 - h]), 32'(exp_q[h][0]));
        got[h].push_back(rsp_dat[h]);
        void'(exp_q[h].pop_front());
        void'(pend_q.pop_front());
        void'(sdq.pop_front());
      end
    end
    if (fire) begin
      fired.push_back(g);
      last_port = g;
      held = 1'b0;
      idx = int'(c_addr[g][2:0]);
      if (c_write[g]) begin
        if (c_mask[g][0]) mem[idx][7:0]  = c_data[g][7:0];
        if (c_mask[g][1]) mem[idx][15:8] = c_data[g][15:8];
      end else begin
        pend_q.push_back(g);
        sdq.push_back(mem[idx]);
        exp_q[g].push_back(mem[idx]);
      end
      void'(cmdq[g].pop_front());
    end else if (ev) begin
      held = 1'b1;
      held_port = g;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      c_valid[n] = 1'b0; r_ready[n] = 1'b0;
      cmdq[n].delete(); exp_q[n].delete(); got[n].delete();
      rdy_prob[n] = 100;
    end
    io_cmd_ready = 1'b0; io_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pend_q.delete(); sdq.delete(); fired.delete();
    last_port = 1; held = 1'b0; held_port = 0; exp_ovf = 1'b0; inject = 1'b0;
    cmd_prob = 100; rsp_prob = 100;
  endtask

  task automatic run_until_got(input int n, input int cnt, input int budget, input string name);
    int b;
    b = 0;
    while (got[n].size() < cnt && b < budget) begin
      cycle();
      b++;
    end
    chk(name, 32'(got[n].size()), 32'(cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    cmd_t c;
    // reset state: rr_last=1 (p0 wins a tie), FIFO empty, no lock
    vt[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000, 1'b0, 1'b0);
    vt[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h100, 1'b1, 1'b0);
    vt[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h200, 1'b0, 1'b1);
    vt[3] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h100, 1'b1, 1'b0);
    vt[4] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h100, 1'b0, 1'b0);
    vt[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h100, 1'b1, 1'b0);
    vt[6] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h100, 1'b1, 1'b0);
    vt[7] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int n = 0; n < 2; n++) begin
      c_valid[n] = 1'b0; c_write[n] = 1'b0; c_data[n] = 16'h1234; c_mask[n] = 2'b11;
      r_ready[n] = 1'b0; rdy_prob[n] = 100;
    end
    c_addr[0] = 24'h100; c_addr[1] = 24'h200;
    io_cmd_ready = 1'b0; io_rsp_valid = 1'b0; io_rsp_payload_data = '0;
    inject = 1'b0;

    // Vector table, reset held low so every vector sees the reset state.
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_valid[0] = vt[i].v0; c_write[0] = vt[i].w0;
      c_valid[1] = vt[i].v1; c_write[1] = vt[i].w1;
      io_cmd_ready = vt[i].cr; io_rsp_valid = vt[i].rv;
      #1;
      chk($sformatf("vec%0d io_cmd_valid", i), 32'(io_cmd_valid), 32'(vt[i].ev));
      if (vt[i].ev)
        chk($sformatf("vec%0d io_cmd_address", i), 32'(io_cmd_payload_address), 32'(vt[i].ea));
      if (vt[i].v0)
        chk($sformatf("vec%0d p0_cmd_ready", i), 32'(cmd_rdy[0]), 32'(vt[i].er0));
      if (vt[i].v1)
        chk($sformatf("vec%0d p1_cmd_ready", i), 32'(cmd_rdy[1]), 32'(vt[i].er1));
      chk($sformatf("vec%0d io_rsp_ready", i), 32'(io_rsp_ready), 32'd1);
      chk($sformatf("vec%0d rsp_valid", i), 32'({rsp_vld[1], rsp_vld[0]}), 32'd0);
      chk($sformatf("vec%0d overflow", i), 32'(io_overflow_err), 32'd0);
    end

    // p0 alone: writes then reads come back in order
    do_reset();
    for (int i = 0; i < 3; i++)
      cmdq[0].push_back(mkcmd(1'b1, AW'(24'h10 + i), DW'(16'hA0 + i), 2'b11));
    for (int i = 0; i < 3; i++)
      cmdq[0].push_back(mkcmd(1'b0, AW'(24'h10 + i), 16'h0, 2'b11));
    run_until_got(0, 3, 60, "t1 p0 read count");
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1 read%0d", i), 32'((got[0].size() > i) ? got[0][i] : 16'hFFFF),
          32'(16'hA0 + i));

    // both always valid: strict alternation starting with p0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmdq[0].push_back(mkcmd(1'b1, AW'(i), DW'(16'h0100 + i), 2'b11));
      cmdq[1].push_back(mkcmd(1'b1, AW'(4 + i), DW'(16'h0200 + i), 2'b11));
    end
    repeat (8) cycle();
    chk("t2 fired count", 32'(fired.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2 grant%0d", i), 32'((fired.size() > i) ? fired[i] : 9), 32'(i % 2));

    // stalled p1 command stays on the bus while p0 also requests
    do_reset();
    cmd_prob = 0;
    cmdq[1].push_back(mkcmd(1'b1, 24'h33, 16'h5555, 2'b11));
    cycle();
    cmdq[0].push_back(mkcmd(1'b1, 24'h44, 16'h6666, 2'b11));
    repeat (5) begin
      cycle();
      chk("t3 held valid", 32'(io_cmd_valid), 32'd1);
      chk("t3 held address", 32'(io_cmd_payload_address), 32'h33);
      chk("t3 p0 blocked", 32'(cmd_rdy[0]), 32'd0);
    end
    cmd_prob = 100;
    repeat (2) cycle();
    chk("t3 first fired", 32'((fired.size() > 0) ? fired[0] : 9), 32'd1);
    chk("t3 second fired", 32'((fired.size() > 1) ? fired[1] : 9), 32'd0);

    // FIFO full: fifth read waits, a write from p1 still goes through
    do_reset();
    rsp_prob = 0;
    for (int i = 0; i < 5; i++)
      cmdq[0].push_back(mkcmd(1'b0, AW'(i), 16'h0, 2'b11));
    repeat (6) cycle();
    chk("t4 reads accepted", 32'(fired.size()), 32'd4);
    chk("t4 read left", 32'(cmdq[0].size()), 32'd1);
    chk("t4 gated valid", 32'(io_cmd_valid), 32'd0);
    cmdq[1].push_back(mkcmd(1'b1, 24'h5, 16'h5A5A, 2'b11));
    repeat (2) cycle();
    chk("t4 write accepted", 32'(cmdq[1].size()), 32'd0);
    chk("t4 write grant", 32'((fired.size() > 4) ? fired[4] : 9), 32'd1);
    rsp_prob = 100;
    run_until_got(0, 5, 40, "t4 drain");

    // interleaved reads with p1 back-pressuring its response
    do_reset();
    cmdq[0].push_back(mkcmd(1'b1, 24'h20, 16'h1111, 2'b11));
    cmdq[1].push_back(mkcmd(1'b1, 24'h21, 16'h2222, 2'b11));
    cmdq[0].push_back(mkcmd(1'b0, 24'h20, 16'h0, 2'b11));
    cmdq[1].push_back(mkcmd(1'b0, 24'h21, 16'h0, 2'b11));
    rdy_prob[1] = 0;
    run_until_got(0, 1, 30, "t5 p0 response");
    repeat (3) begin
      cycle();
      chk("t5 p1 waiting", 32'(got[1].size()), 32'd0);
      chk("t5 p1 rsp_valid", 32'(rsp_vld[1]), 32'd1);
    end
    rdy_prob[1] = 100;
    run_until_got(1, 1, 20, "t5 p1 response");
    chk("t5 p0 data", 32'((got[0].size() > 0) ? got[0][0] : 16'hFFFF), 32'h1111);
    chk("t5 p1 data", 32'((got[1].size() > 0) ? got[1][0] : 16'hFFFF), 32'h2222);

    // orphan response: dropped, sticky error until reset
    do_reset();
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    repeat (3) cycle();
    chk("t6 overflow set", 32'(io_overflow_err), 32'd1);
    do_reset();
    chk("t6 overflow cleared", 32'(io_overflow_err), 32'd0);

    // randomized traffic against the reference model
    do_reset();
    cmd_prob = 70; rsp_prob = 60; rdy_prob[0] = 75; rdy_prob[1] = 75;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++)
        if (cmdq[n].size() < 2 && $urandom_range(99) < 40) begin
          c.write = 1'($urandom_range(1));
          c.addr  = AW'($urandom_range(7));
          c.data  = DW'($urandom);
          c.mask  = MW'($urandom_range(3, 1));
          cmdq[n].push_back(c);
        end
      cycle();
    end
    cmd_prob = 100; rsp_prob = 100; rdy_prob[0] = 100; rdy_prob[1] = 100;
    b = 0;
    while ((cmdq[0].size() + cmdq[1].size() + pend_q.size()) > 0 && b < 300) begin
      cycle();
      b++;
    end
    chk("rand drained", 32'(cmdq[0].size() + cmdq[1].size() + pend_q.size()), 32'd0);
    chk("rand exp left", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
